// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks program memory from index 0, presenting each
// word with its index two cycles after it is addressed. It absorbs downstream
// stalls with a one-entry hold buffer, redirects on jump, and stops on the
// halt word or at the last program index.
module fetch_unit #(
    parameter int unsigned          code_size      = 12,
    parameter int unsigned          program_length = 256,
    parameter logic [code_size-1:0] halt_code      = {code_size{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [31:0]          mem_addr,
    input  logic [code_size-1:0] mem_data,
    input  logic                 stall,
    input  logic                 jump,
    input  logic [31:0]          jump_target,
    output logic [code_size-1:0] code,
    output logic [31:0]          code_index,
    output logic                 code_valid,
    output logic                 halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [31:0] last_idx_c = 32'(program_length - 1);

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    // inflight: mem_data in this cycle is a new word that was addressed last cycle
    logic                 inflight_q, inflight_d;
    logic [31:0]          inflight_idx_q, inflight_idx_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [code_size-1:0] hold_data_q, hold_data_d;
    logic [31:0]          hold_idx_q, hold_idx_d;
    logic [code_size-1:0] code_q, code_d;
    logic [31:0]          code_index_q, code_index_d;
    logic                 code_valid_q, code_valid_d;
    logic                 halted_q, halted_d;

    // Next-state, pc, hold-buffer and output-word computation.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inflight_d     = 1'b0;
        inflight_idx_d = inflight_idx_q;
        hold_valid_d   = hold_valid_q;
        hold_data_d    = hold_data_q;
        hold_idx_d     = hold_idx_q;
        code_d         = code_q;
        code_index_d   = code_index_q;
        code_valid_d   = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d      = FETCH;
                    pc_d         = 32'd0;
                    hold_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            FETCH: begin
                if (jump) begin
                    // Redirect: drop the in-flight word and anything held.
                    pc_d         = jump_target;
                    hold_valid_d = 1'b0;
                end else if (stall) begin
                    // Park the one word already on its way; the address stays
                    // put, so later reads simply repeat and are not new.
                    if (inflight_q && !hold_valid_q) begin
                        hold_valid_d = 1'b1;
                        hold_data_d  = mem_data;
                        hold_idx_d   = inflight_idx_q;
                    end else begin
                        hold_valid_d = hold_valid_q;
                    end
                end else begin
                    pc_d           = pc_q + 32'd1;
                    inflight_d     = 1'b1;
                    inflight_idx_d = pc_q;
                    // The held word is always older than anything in flight.
                    if (hold_valid_q) begin
                        code_d       = hold_data_q;
                        code_index_d = hold_idx_q;
                        code_valid_d = 1'b1;
                        hold_valid_d = 1'b0;
                    end else if (inflight_q) begin
                        code_d       = mem_data;
                        code_index_d = inflight_idx_q;
                        code_valid_d = 1'b1;
                    end else begin
                        code_valid_d = 1'b0;
                    end
                    // Stop on the halt word or the last program word; freeze pc.
                    if (code_valid_d && ((code_d == halt_code) || (code_index_d == last_idx_c))) begin
                        state_d    = HALT;
                        pc_d       = pc_q;
                        inflight_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        halted_d = (state_q == HALT) && (state_d == HALT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pc_q           <= 32'd0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= 32'd0;
            hold_valid_q   <= 1'b0;
            hold_data_q    <= {code_size{1'b0}};
            hold_idx_q     <= 32'd0;
            code_q         <= {code_size{1'b0}};
            code_index_q   <= 32'd0;
            code_valid_q   <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            hold_idx_q     <= hold_idx_d;
            code_q         <= code_d;
            code_index_q   <= code_index_d;
            code_valid_q   <= code_valid_d;
            halted_q       <= halted_d;
        end
    end

    assign mem_addr   = pc_q;
    assign code       = code_q;
    assign code_index = code_index_q;
    assign code_valid = code_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Cycle n counts clock edges after the first
// FETCH cycle (cycle 0, pc=0); inputs driven in cycle n are seen at the edge
// ending cycle n. Outputs are sampled 1 time unit after each rising edge.
module tb_fetch_unit;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a, stall_a, jump_a;
    logic [31:0]   jump_target_a, mem_addr_a, code_index_a;
    logic [CW-1:0] mem_data_a, code_a;
    logic          code_valid_a, halted_a;
    logic          start_b, stall_b, jump_b;
    logic [31:0]   jump_target_b, mem_addr_b, code_index_b;
    logic [CW-1:0] mem_data_b, code_b;
    logic          code_valid_b, halted_b;

    logic [CW-1:0] mem_a [0:255];
    logic [CW-1:0] mem_b [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .stall(stall_a), .jump(jump_a),
        .jump_target(jump_target_a), .code(code_a), .code_index(code_index_a),
        .code_valid(code_valid_a), .halted(halted_a)
    );

    fetch_unit #(.program_length(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .stall(stall_b), .jump(jump_b),
        .jump_target(jump_target_b), .code(code_b), .code_index(code_index_b),
        .code_valid(code_valid_b), .halted(halted_b)
    );

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        if (mem_addr_a < 32'd256) mem_data_a <= mem_a[mem_addr_a[7:0]];
        else                      mem_data_a <= '0;
        if (mem_addr_b < 32'd256) mem_data_b <= mem_b[mem_addr_b[7:0]];
        else                      mem_data_b <= '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut_a; returns in cycle 0.
    task automatic start_run_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; stall_a = 1'b0; jump_a = 1'b0; jump_target_a = 32'd0;
        start_b = 1'b0; stall_b = 1'b0; jump_b = 1'b0; jump_target_b = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = CW'(i + 1);
            mem_b[i] = CW'(i + 1);
        end
        tick();
        tick();

        // Reset state
        check("rst_code",     32'(code_a),       32'd0);
        check("rst_index",    code_index_a,      32'd0);
        check("rst_valid",    32'(code_valid_a), 32'd0);
        check("rst_halted",   32'(halted_a),     32'd0);
        check("rst_mem_addr", mem_addr_a,        32'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_valid",   32'(code_valid_a), 32'd0);
        check("idle_b_valid", 32'(code_valid_b), 32'd0);

        // Basic sequence + stall driven in cycles 4-6
        start_run_a();
        check("basic_c0_addr", mem_addr_a, 32'd0);
        tick();
        check("basic_c1_valid", 32'(code_valid_a), 32'd0);
        tick();
        check("basic_c2_code",  32'(code_a), 32'd1);
        check("basic_c2_index", code_index_a, 32'd0);
        check("basic_c2_valid", 32'(code_valid_a), 32'd1);
        tick();
        check("basic_c3_code",  32'(code_a), 32'd2);
        check("basic_c3_index", code_index_a, 32'd1);
        check("basic_c3_valid", 32'(code_valid_a), 32'd1);
        tick();
        check("basic_c4_code",  32'(code_a), 32'd3);
        check("basic_c4_index", code_index_a, 32'd2);
        check("basic_c4_valid", 32'(code_valid_a), 32'd1);
        stall_a = 1'b1;
        tick();
        check("stall_c5_valid", 32'(code_valid_a), 32'd0);
        check("stall_c5_index", code_index_a, 32'd2);
        check("stall_c5_code",  32'(code_a), 32'd3);
        check("stall_c5_addr",  mem_addr_a, 32'd4);
        tick();
        check("stall_c6_valid", 32'(code_valid_a), 32'd0);
        check("stall_c6_index", code_index_a, 32'd2);
        tick();
        check("stall_c7_valid", 32'(code_valid_a), 32'd0);
        check("stall_c7_addr",  mem_addr_a, 32'd4);
        stall_a = 1'b0;
        tick();
        check("stall_c8_valid", 32'(code_valid_a), 32'd1);
        check("stall_c8_index", code_index_a, 32'd3);
        check("stall_c8_code",  32'(code_a), 32'd4);
        check("stall_c8_addr",  mem_addr_a, 32'd5);
        tick();
        check("stall_c9_valid", 32'(code_valid_a), 32'd1);
        check("stall_c9_index", code_index_a, 32'd4);
        check("stall_c9_code",  32'(code_a), 32'd5);
        tick();
        check("stall_c10_index", code_index_a, 32'd5);

        // Jump in cycle 5, together with stall and start (jump must win)
        pulse_rst();
        start_run_a();
        repeat (5) tick();
        check("jump_c5_index", code_index_a, 32'd3);
        check("jump_c5_valid", 32'(code_valid_a), 32'd1);
        jump_a = 1'b1; jump_target_a = 32'd100; stall_a = 1'b1; start_a = 1'b1;
        tick();
        jump_a = 1'b0; stall_a = 1'b0; start_a = 1'b0;
        check("jump_c6_valid", 32'(code_valid_a), 32'd0);
        check("jump_c6_addr",  mem_addr_a, 32'd100);
        tick();
        check("jump_c7_valid", 32'(code_valid_a), 32'd0);
        check("jump_c7_addr",  mem_addr_a, 32'd101);
        tick();
        check("jump_c8_valid", 32'(code_valid_a), 32'd1);
        check("jump_c8_index", code_index_a, 32'd100);
        check("jump_c8_code",  32'(code_a), 32'd101);
        tick();
        check("jump_c9_index", code_index_a, 32'd101);
        check("jump_c9_code",  32'(code_a), 32'd102);

        // Halt word at index 3
        mem_a[3] = 12'hFFF;
        pulse_rst();
        start_run_a();
        repeat (4) tick();
        check("halt_c4_index", code_index_a, 32'd2);
        tick();
        check("halt_c5_code",   32'(code_a), 32'hFFF);
        check("halt_c5_index",  code_index_a, 32'd3);
        check("halt_c5_valid",  32'(code_valid_a), 32'd1);
        check("halt_c5_halted", 32'(halted_a), 32'd0);
        tick();
        check("halt_c6_valid",  32'(code_valid_a), 32'd0);
        check("halt_c6_halted", 32'(halted_a), 32'd1);
        check("halt_c6_addr",   mem_addr_a, 32'd4);
        jump_a = 1'b1; jump_target_a = 32'd50; stall_a = 1'b1;
        tick();
        jump_a = 1'b0; stall_a = 1'b0;
        check("halt_c7_addr",   mem_addr_a, 32'd4);
        check("halt_c7_valid",  32'(code_valid_a), 32'd0);
        check("halt_c7_halted", 32'(halted_a), 32'd1);
        tick();
        check("halt_c8_valid", 32'(code_valid_a), 32'd0);
        start_run_a();
        check("restart_c0_halted", 32'(halted_a), 32'd0);
        check("restart_c0_addr",   mem_addr_a, 32'd0);
        tick();
        tick();
        check("restart_c2_valid", 32'(code_valid_a), 32'd1);
        check("restart_c2_index", code_index_a, 32'd0);
        check("restart_c2_code",  32'(code_a), 32'd1);
        mem_a[3] = 12'd4;

        // Reset while stalled with the hold buffer full
        pulse_rst();
        start_run_a();
        repeat (4) tick();
        stall_a = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_code",   32'(code_a), 32'd0);
        check("rstmid_index",  code_index_a, 32'd0);
        check("rstmid_valid",  32'(code_valid_a), 32'd0);
        check("rstmid_halted", 32'(halted_a), 32'd0);
        check("rstmid_addr",   mem_addr_a, 32'd0);
        tick();
        rst = 1'b0;
        stall_a = 1'b0;
        tick();
        check("rstmid_idle1_valid", 32'(code_valid_a), 32'd0);
        tick();
        check("rstmid_idle2_valid", 32'(code_valid_a), 32'd0);
        start_run_a();
        tick();
        check("rstmid_c1_valid", 32'(code_valid_a), 32'd0);
        tick();
        check("rstmid_c2_valid", 32'(code_valid_a), 32'd1);
        check("rstmid_c2_index", code_index_a, 32'd0);
        check("rstmid_c2_code",  32'(code_a), 32'd1);

        // End of program on dut_b (program_length = 4)
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check($sformatf("eop_c%0d_valid", c), 32'(code_valid_b),
                  ((c >= 2) && (c <= 5)) ? 32'd1 : 32'd0);
            if ((c >= 2) && (c <= 5)) begin
                check($sformatf("eop_c%0d_index", c), code_index_b, 32'(c - 2));
                check($sformatf("eop_c%0d_code", c), 32'(code_b), 32'(c - 1));
            end
            check($sformatf("eop_c%0d_halted", c), 32'(halted_b),
                  (c >= 6) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
